// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive controller slice.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ARM     = 3'd1,
        ST_LISTEN  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_HALT    = 3'd4
    } rx_state_e;

    localparam int UART_ERR_CNT_W = 8;
    localparam int UART_DATA_W    = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with registered head (out_valid/out_data); a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             rx_Clk,
    input  logic             rx_Rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic             push_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & (~full | pop);

    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        level_nxt  = level;
        if (push_ok && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    always_ff @(posedge rx_Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
        if (!rx_Rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push_ok);
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            // When nothing stored survives this cycle the new head is the byte being written.
            if (level_nxt != '0) begin
                out_data <= (level == LVL_W'(pop)) ? push_data : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver enable, buffers bytes, counts errors and halts on repeats.
// Optional idle-gap timeout pulse is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int RECOVER_CYCLES = 16,
    parameter int MAX_ERRORS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          rx_Clk,
    input  logic                          rx_Rst_n,
    input  logic                          ctrl_en,
    input  logic                          clear_halt,
    output logic                          rx_enable,
    input  logic                          rx_valid,
    input  logic                          rx_active,
    input  logic [UART_DATA_W-1:0]        rx_byte,
    input  logic                          rx_error,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [UART_DATA_W-1:0]        out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic [UART_ERR_CNT_W-1:0]     err_count,
    output logic                          halted,
    output logic                          timeout
);

    localparam int                REC_W    = $clog2(RECOVER_CYCLES + 1);
    localparam logic [REC_W-1:0]  REC_LOAD = REC_W'(RECOVER_CYCLES - 1);

    rx_state_e                   state;
    logic [REC_W-1:0]            rec_cnt;
    logic [UART_ERR_CNT_W-1:0]   consec;
    logic                        rx_error_q;
    logic                        err_evt;
    logic                        push_req;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;

    // err_evt is the registered rising edge; a byte arriving while it is high is discarded.
    assign push_req = (state == ST_LISTEN) & ctrl_en & rx_valid & ~err_evt;
    assign fifo_pop = out_valid & out_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .rx_Clk    (rx_Clk),
        .rx_Rst_n  (rx_Rst_n),
        .push      (push_req),
        .push_data (rx_byte),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (fifo_level)
    );

    always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
        if (!rx_Rst_n) begin
            rx_error_q <= 1'b0;
            err_evt    <= 1'b0;
        end else begin
            rx_error_q <= rx_error;
            err_evt    <= rx_error & ~rx_error_q;
        end
    end

    always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
        if (!rx_Rst_n) begin
            state     <= ST_OFF;
            rec_cnt   <= '0;
            consec    <= '0;
            err_count <= '0;
            rx_enable <= 1'b0;
            halted    <= 1'b0;
        end else if (!ctrl_en) begin
            state     <= ST_OFF;
            rx_enable <= 1'b0;
            halted    <= 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state     <= ST_ARM;
                    rec_cnt   <= REC_LOAD;
                    consec    <= '0;
                    err_count <= '0;
                end
                ST_ARM, ST_RECOVER: begin
                    if (rec_cnt == '0) begin
                        state     <= ST_LISTEN;
                        rx_enable <= 1'b1;
                    end else begin
                        rec_cnt <= rec_cnt - REC_W'(1);
                    end
                end
                ST_LISTEN: begin
                    if (err_evt) begin
                        if (err_count != '1) begin
                            err_count <= err_count + UART_ERR_CNT_W'(1);
                        end
                        consec    <= consec + UART_ERR_CNT_W'(1);
                        rx_enable <= 1'b0;
                        if (consec == UART_ERR_CNT_W'(MAX_ERRORS - 1)) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state   <= ST_RECOVER;
                            rec_cnt <= REC_LOAD;
                        end
                    end else if (rx_valid) begin
                        consec <= '0;
                    end
                end
                ST_HALT: begin
                    if (clear_halt) begin
                        state   <= ST_ARM;
                        rec_cnt <= REC_LOAD;
                        consec  <= '0;
                        halted  <= 1'b0;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
        if (!rx_Rst_n) begin
            overrun <= 1'b0;
        end else if (state == ST_OFF && ctrl_en) begin
            overrun <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            overrun <= 1'b1;
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_run;

    always_ff @(posedge rx_Clk or negedge rx_Rst_n) begin
        if (!rx_Rst_n) begin
            to_cnt  <= TO_LOAD;
            to_run  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state != ST_LISTEN) begin
                to_cnt <= TO_LOAD;
            end else if (push_req) begin
                to_cnt <= TO_LOAD;
                to_run <= 1'b1;
            end else if (to_run && !fifo_empty && !rx_active) begin
                if (to_cnt == '0) begin
                    timeout <= 1'b1;
                    to_run  <= 1'b0;
                    to_cnt  <= TO_LOAD;
                end else begin
                    to_cnt <= to_cnt - TO_W'(1);
                end
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = rx_active ^ fifo_empty ^ (TIMEOUT_CYCLES > 0);
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with default parameters (depth 8, recover 16, max errors 4).
module tb_uart_rx_ctrl;

    logic       rx_Clk;
    logic       rx_Rst_n;
    logic       ctrl_en;
    logic       clear_halt;
    logic       rx_enable;
    logic       rx_valid;
    logic       rx_active;
    logic [7:0] rx_byte;
    logic       rx_error;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] fifo_level;
    logic       overrun;
    logic [7:0] err_count;
    logic       halted;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl dut (
        .rx_Clk     (rx_Clk),
        .rx_Rst_n   (rx_Rst_n),
        .ctrl_en    (ctrl_en),
        .clear_halt (clear_halt),
        .rx_enable  (rx_enable),
        .rx_valid   (rx_valid),
        .rx_active  (rx_active),
        .rx_byte    (rx_byte),
        .rx_error   (rx_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .err_count  (err_count),
        .halted     (halted),
        .timeout    (timeout)
    );

    initial begin
        rx_Clk = 1'b0;
        forever #5 rx_Clk = ~rx_Clk;
    end

    task automatic step();
        @(posedge rx_Clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_listen(input string name);
        for (int i = 0; i < 64 && rx_enable !== 1'b1; i++) step();
        checks++;
        if (rx_enable !== 1'b1) begin
            errors++;
            $display("FAIL %s rx_enable got %b exp 1 within 64 cycles", name, rx_enable);
        end
    endtask

    task automatic test_reset();
        rx_Rst_n = 1'b0; ctrl_en = 1'b0; clear_halt = 1'b0; rx_valid = 1'b0;
        rx_active = 1'b0; rx_byte = 8'h00; rx_error = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++; if (rx_enable !== 1'b0) begin errors++; $display("FAIL reset_rx_enable got %b exp 0", rx_enable); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        rx_Rst_n = 1'b1;
        step();
    endtask

    task automatic test_arm();
        logic exp_en;
        ctrl_en = 1'b1;
        step();
        checks++; if (rx_enable !== 1'b0) begin errors++; $display("FAIL arm_entry_enable got %b exp 0", rx_enable); end
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_en = (k == 16);
            checks++;
            if (rx_enable !== exp_en) begin
                errors++;
                $display("FAIL arm_enable edge %0d got %b exp %b", k, rx_enable, exp_en);
            end
        end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        push_byte(8'h55);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL first_push got v=%b d=%h exp v=1 d=55", out_valid, out_data); end
        push_byte(8'hA3);
        checks++; if (fifo_level !== 4'd2 || out_data !== 8'h55) begin errors++; $display("FAIL two_push got lvl=%0d d=%h exp lvl=2 d=55", fifo_level, out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA3 || fifo_level !== 4'd1) begin errors++; $display("FAIL pop1 got v=%b d=%h lvl=%0d exp v=1 d=a3 lvl=1", out_valid, out_data, fifo_level); end
        step();
        checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL pop2 got v=%b lvl=%0d exp v=0 lvl=0", out_valid, fifo_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] exp_d;
        for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
        checks++; if (fifo_level !== 4'd8 || overrun !== 1'b1 || out_data !== 8'h10) begin errors++; $display("FAIL overrun_full got lvl=%0d ovr=%b d=%h exp lvl=8 ovr=1 d=10", fifo_level, overrun, out_data); end
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_d = 8'h10 + 8'(k);
            checks++;
            if (k < 8 && (out_valid !== 1'b1 || out_data !== exp_d)) begin errors++; $display("FAIL drain_a pop %0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d); end
            else if (k == 8 && (out_valid !== 1'b0 || fifo_level !== 4'd0)) begin errors++; $display("FAIL drain_a_empty got v=%b lvl=%0d exp v=0 lvl=0", out_valid, fifo_level); end
        end
        out_ready = 1'b0;
        ctrl_en = 1'b0; step();
        ctrl_en = 1'b1; step();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", overrun); end
        wait_listen("rearm_overrun");
        for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
        out_ready = 1'b1;
        push_byte(8'h28);
        out_ready = 1'b0;
        checks++; if (fifo_level !== 4'd8 || overrun !== 1'b0 || out_data !== 8'h21) begin errors++; $display("FAIL full_push_pop got lvl=%0d ovr=%b d=%h exp lvl=8 ovr=0 d=21", fifo_level, overrun, out_data); end
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_d = 8'h21 + 8'(k);
            checks++;
            if (k < 8 && (out_valid !== 1'b1 || out_data !== exp_d)) begin errors++; $display("FAIL drain_b pop %0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d); end
            else if (k == 8 && (out_valid !== 1'b0 || fifo_level !== 4'd0)) begin errors++; $display("FAIL drain_b_empty got v=%b lvl=%0d exp v=0 lvl=0", out_valid, fifo_level); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic exp_en;
        out_ready = 1'b1;
        for (int e = 0; e < 3; e++) begin
            push_byte(8'h01 + 8'(e));
            rx_error = 1'b1;
            step();
            rx_error = 1'b0;
            checks++; if (rx_enable !== 1'b1) begin errors++; $display("FAIL err%0d_edge_n got %b exp 1", e, rx_enable); end
            step();
            checks++; if (rx_enable !== 1'b0) begin errors++; $display("FAIL err%0d_edge_n1 got %b exp 0", e, rx_enable); end
            for (int k = 1; k <= 16; k++) begin
                step();
                exp_en = (k == 16);
                checks++;
                if (rx_enable !== exp_en) begin errors++; $display("FAIL err%0d_recover edge %0d got %b exp %b", e, k, rx_enable, exp_en); end
            end
        end
        checks++; if (err_count !== 8'd3 || halted !== 1'b0) begin errors++; $display("FAIL three_errors got cnt=%0d halt=%b exp cnt=3 halt=0", err_count, halted); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL errors_fifo got %0d exp 0", fifo_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_halt();
        out_ready = 1'b1;
        push_byte(8'h02);
        for (int e = 0; e < 4; e++) begin
            rx_error = 1'b1; step();
            rx_error = 1'b0; step();
            if (e < 3) begin
                checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early err %0d got %b exp 0", e, halted); end
                wait_listen("halt_recover");
            end
        end
        repeat (5) step();
        checks++; if (halted !== 1'b1 || rx_enable !== 1'b0 || err_count !== 8'd7) begin errors++; $display("FAIL halt_state got halt=%b en=%b cnt=%0d exp halt=1 en=0 cnt=7", halted, rx_enable, err_count); end
        clear_halt = 1'b1; step();
        clear_halt = 1'b0;
        checks++; if (halted !== 1'b0 || rx_enable !== 1'b0) begin errors++; $display("FAIL clear_halt got halt=%b en=%b exp halt=0 en=0", halted, rx_enable); end
        wait_listen("clear_halt_listen");
        out_ready = 1'b0;
    endtask

    task automatic test_valid_error();
        out_ready = 1'b0;
        push_byte(8'h3C);
        rx_error = 1'b1; step();
        rx_error = 1'b0; rx_valid = 1'b1; rx_byte = 8'h77; step();
        rx_valid = 1'b0;
        checks++; if (fifo_level !== 4'd1 || out_data !== 8'h3C) begin errors++; $display("FAIL collide_fifo got lvl=%0d d=%h exp lvl=1 d=3c", fifo_level, out_data); end
        checks++; if (err_count !== 8'd8 || rx_enable !== 1'b0) begin errors++; $display("FAIL collide_err got cnt=%0d en=%b exp cnt=8 en=0", err_count, rx_enable); end
        repeat (5) step();
        ctrl_en = 1'b0;
        repeat (20) step();
        checks++; if (rx_enable !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL off_state got en=%b halt=%b exp en=0 halt=0", rx_enable, halted); end
        checks++; if (err_count !== 8'd8 || fifo_level !== 4'd1) begin errors++; $display("FAIL off_retain got cnt=%0d lvl=%0d exp cnt=8 lvl=1", err_count, fifo_level); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL off_drain got v=%b lvl=%0d exp v=0 lvl=0", out_valid, fifo_level); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at_k = -1;
        ctrl_en = 1'b1; step();
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rearm_err_clear got %0d exp 0", err_count); end
        wait_listen("timeout_listen");
        rx_active = 1'b0;
        push_byte(8'hC3);
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (timeout === 1'b1) begin
                pulses++;
                at_k = k;
            end
        end
`ifdef UART_RX_CTRL_TIMEOUT_EN
        checks++; if (pulses != 1 || at_k != 1024) begin errors++; $display("FAIL timeout_pulse got n=%0d at=%0d exp n=1 at=1024", pulses, at_k); end
`else
        checks++; if (pulses != 0) begin errors++; $display("FAIL timeout_absent got n=%0d exp n=0", pulses); end
`endif
    endtask

    task automatic test_async_reset();
        #2;
        rx_Rst_n = 1'b0;
        #1;
        checks++; if (fifo_level !== 4'd0 || out_valid !== 1'b0 || rx_enable !== 1'b0) begin errors++; $display("FAIL async_reset got lvl=%0d v=%b en=%b exp 0 0 0", fifo_level, out_valid, rx_enable); end
        rx_Rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_arm();
        test_push_pop();
        test_overrun();
        test_errors();
        test_halt();
        test_valid_error();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences the UART receiver and buffers its output for the host. It drives the receiver's `enable`, collects received bytes into a small FIFO with a valid/ready read port, and counts framing errors. After each error it forces a receiver reset by holding `enable` low for a recovery interval. After too many consecutive errors it halts. It sits between the `rx` receiver instance and the host/bus logic.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: byte FIFO entries; power of 2, ≥2.
- `RECOVER_CYCLES`, 16: cycles `rx_enable` is held low in ARM/RECOVER; ≥1.
- `MAX_ERRORS`, 4: consecutive errors that cause HALT; 1..255.
- `TIMEOUT_CYCLES`, 1024: idle-gap threshold; used only with `UART_RX_CTRL_TIMEOUT_EN`.

Ports:
- `rx_Clk`  in  1  sole clock; one clock, all logic on rising edge.
- `rx_Rst_n`  in  1  reset, asynchronous, active-low.
- `ctrl_en`  in  1  level; 1 = run receiver.
- `clear_halt`  in  1  one-cycle pulse; leaves HALT.
- `rx_enable`  out  1  to receiver `enable`.
- `rx_valid`  in  1  receiver byte-valid.
- `rx_active`  in  1  receiver busy.
- `rx_byte`  in  8  receiver data, bits [7:0] of its output.
- `rx_error`  in  1  receiver error.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  host accepts head.
- `out_data`  out  8  FIFO head byte.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `overrun`  out  1  sticky; byte lost to full FIFO.
- `err_count`  out  8  total errors, saturating at 255.
- `halted`  out  1  high in HALT.
- `timeout`  out  1  one-cycle idle-gap pulse.

## Operation
- States: OFF, ARM, LISTEN, RECOVER, HALT. Reset state is OFF.
- OFF: `rx_enable`=0. Moves to ARM when `ctrl_en`=1. On OFF→ARM, `overrun`, `err_count` and the consecutive-error count clear.
- ARM and RECOVER: `rx_enable`=0 for exactly RECOVER_CYCLES cycles, then move to LISTEN.
- LISTEN: `rx_enable`=1.
  - `rx_valid`=1 pushes `rx_byte` and clears the consecutive-error count.
  - An error event (rising edge of `rx_error`, registered edge detect) increments `err_count` (saturating) and the consecutive count.
  - If the consecutive count reaches MAX_ERRORS, go to HALT; otherwise go to RECOVER.
- HALT: `rx_enable`=0, `halted`=1. `clear_halt` goes to ARM and clears the consecutive count.
- `ctrl_en`=0 in any state forces OFF on the next edge. FIFO contents and counters are retained, and the FIFO stays drainable.
- `rx_valid` and `rx_error` are ignored outside LISTEN.
- `rx_valid` and an error event in the same cycle: the error wins and the byte is discarded.
- FIFO push and full:
  - When full and no pop this cycle, a push is dropped and `overrun` is set.
  - When full with a pop in the same cycle, the push is accepted.
- FIFO pop: occurs when `out_valid`&`out_ready`. Push and pop together leave `fifo_level` unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. `fifo_level` is maintained separately, in the range 0..FIFO_DEPTH.

## Timing
- All outputs are registered.
- Reset values: `rx_enable`=0, `out_valid`=0, `out_data`=0, `fifo_level`=0, `overrun`=0, `err_count`=0, `halted`=0, `timeout`=0.
- `ctrl_en` rises before edge 0 → ARM after edge 0 → `rx_enable`=1 after edge RECOVER_CYCLES.
- `rx_valid` at edge n into an empty FIFO → `out_valid`=1 and `out_data` valid after edge n.
- Error edge sampled at edge n → `rx_enable`=0 after edge n+1. It returns high RECOVER_CYCLES edges after that.
- `out_data` holds while `out_valid`&!`out_ready`. After a pop, the next head is presented on the following cycle.
- Async reset mid-frame returns to OFF immediately and empties the FIFO.

## Configuration
- `UART_RX_CTRL_TIMEOUT_EN` defined:
  - In LISTEN, a counter runs while FIFO is non-empty and `rx_active`=0. It clears on every push.
  - When the counter reaches TIMEOUT_CYCLES, `timeout` pulses for one cycle. The counter then stops until the next push.
  - The counter is cleared outside LISTEN.
- Undefined: the counter is absent and `timeout` is tied 0. The port list is unchanged.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (OFF/ARM/LISTEN/RECOVER/HALT);
  - `UART_ERR_CNT_W`=8;
  - `UART_DATA_W`=8.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push/pop/full/empty/level and the same-cycle full push+pop rule.
- The state machine, recovery counter, error counting and timeout logic stay in `uart_rx_ctrl`.

## Test plan
- Reset, then `ctrl_en`=1 with RECOVER_CYCLES=16 → `rx_enable` rises exactly 16 edges after ARM entry. All outputs are 0 before that.
- Push 0x55 and 0xA3 with `out_ready`=0 → `fifo_level`=2, `out_data`=0x55. Raise `out_ready` → 0x55 then 0xA3 are popped, `out_valid` drops, `fifo_level`=0.
- With FIFO_DEPTH=8, push 9 bytes with no pop → `fifo_level`=8 and `overrun`=1. Repeat with a pop on the 9th push cycle → 9th byte accepted and `overrun` stays 0.
- Inject 3 errors separated by valid bytes → `err_count`=3, never HALT. Inject 4 back-to-back errors → `halted`=1, `rx_enable`=0. Pulse `clear_halt` → ARM then LISTEN.
- Assert `rx_valid` with an `rx_error` rising edge in the same cycle → no push, `err_count`+1, RECOVER entered. Drop `ctrl_en` mid-RECOVER → OFF, FIFO still drains.
- With `UART_RX_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=1024: push 1 byte, then hold `rx_active`=0 → a single `timeout` pulse at 1024 cycles. Without the macro → `timeout` stays 0.
